plru_state_array: RTL and testbench
===================================

// Module: plru_state_array
// PURPOSE
//  Per-set tree pseudo-LRU state store for the N-way pipelined cache, with built-in update logic.
//  Port 0 is a lookup port that returns the stored state and the victim way for one set.
//  Port 1 is a touch port that marks one way of one set most-recently-used, as a read-modify-write.
//  Sits beside the tag/data arrays; the replacement logic consumes victim0 directly.
// PARAMETERS
//  S_INDEX   4  set-index width; NUM_SETS = 2**S_INDEX
//  NUM_WAYS  4  associativity; power of two, >= 2
//  WAY_IDX   $clog2(NUM_WAYS)  localparam; way-number width
//  WIDTH     NUM_WAYS-1        localparam; PLRU bits per set
// PORTS
//  clk0     in   1        clock; single clock domain
//  rst0     in   1        reset; synchronous, active-high
//  ready    out  1        1 = array accepts requests
//  csb0     in   1        port 0 select, active-low; lookup request
//  addr0    in   S_INDEX  port 0 set index
//  state0   out  WIDTH    PLRU bits of the last accepted lookup set
//  victim0  out  WAY_IDX  way selected by state0
//  csb1     in   1        port 1 select, active-low
//  web1     in   1        port 1 write enable, active-low; csb1=0 and web1=0 = touch
//  addr1    in   S_INDEX  port 1 set index
//  way1     in   WAY_IDX  way being touched
// BEHAVIOUR
//  - Encoding: heap order. Node 0 is the root; node i has children 2i+1 and 2i+2.
//    - Bit = 0: victim lies in the lower-way subtree.
//    - Bit = 1: victim lies in the upper-way subtree.
//  - victim0: walk from the root following the bits; WAY_IDX levels.
//  - Touch update: each node on way1's path is set to point away from way1. Off-path bits are unchanged.
//  - Lookup, 1-cycle latency:
//    - An accepted request (csb0=0, ready=1) at edge E captures addr0 into addr0_reg.
//    - state0 and victim0 are combinational from addr0_reg during the cycle after E.
//    - Outputs are held until the next accepted lookup.
//  - Touch pipeline:
//    - An accepted touch at edge E captures addr1/way1 and sets pend=1.
//    - In the following cycle, upd = f(array[addr1_reg], way1_reg).
//    - upd is written at edge E+1.
//    - csb1=0 with web1=1 is a no-op.
//  - Forwarding: when pend=1 and addr0_reg==addr1_reg, state0/victim0 are computed from upd, not from the array.
//  - Back-to-back touches to one set: the second read-modify-write sees the first one's committed value. No stall.
//  - Requests issued while ready=0 are ignored entirely; captured registers are unchanged.
//  - Reset (rst0=1 at an edge):
//    - pend=0 and addr0_reg=0.
//    - state0=0 and victim0=0 in the first cycle after reset.
//    - A pending touch is dropped.
// CONFIGURATION
//  LRU_INIT_SWEEP_EN undefined:
//    - Reset clears all NUM_SETS entries to 0 in one cycle.
//    - ready=1 from the first cycle after reset.
//  LRU_INIT_SWEEP_EN defined (single-port-RAM friendly):
//    - FSM states: INIT and RUN. Reset enters INIT with cnt=0.
//    - INIT writes 0 to set cnt each cycle, with ready=0.
//    - On cnt==NUM_SETS-1, go to RUN; ready=1 on the next cycle.
//    - A reset during INIT restarts at cnt=0.
//    - The array is not reset otherwise.
//    - state0/victim0 read as 0 during INIT.
// TESTING (NUM_WAYS=4, S_INDEX=4)
//  - Reset, then lookup set 5: state0=3'b000, victim0=0. With sweep enabled, ready=0 for 16 cycles first.
//  - Touch set 5 way 0, lookup 5 two cycles later: state0=3'b011, victim0=2.
//    Then touch way 2 and lookup: state0=3'b110, victim0=1.
//  - Touch set 3 way 3 and lookup set 3 in the same cycle: the lookup result is the forwarded upd, state0=3'b000, victim0=0.
//    For touch way 1 instead: state0=3'b001, victim0=2.
//  - Touch set 7 ways 0,1,2,3 on consecutive cycles, then lookup: state0=3'b000, victim0=0. Each step sees the prior commit.
//  - Touch pending to set 9, rst0 asserted next edge: set 9 stays 3'b000.
//    With sweep enabled, assert rst0 at cnt=8: sweep restarts and ready rises 16 cycles later.
//  - Random touches plus lookups against a tree-PLRU model, 10k cycles: state0/victim0 match every cycle.

Source files
------------

// File: rtl/plru_state_array.sv
// Tree pseudo-LRU state store with a lookup port and a read-modify-write touch port.
// The optional init sweep is enabled by defining LRU_INIT_SWEEP_EN.
//
// Ports:
//   clk0, rst0       clock; synchronous active-high reset
//   ready            high when requests are accepted
//   csb0/addr0       lookup select (active-low) and set index
//   state0/victim0   PLRU bits and victim way of the last accepted lookup set
//   csb1/web1        touch select and write enable (both active-low for a touch)
//   addr1/way1       touch set index and way being marked most-recently-used
module plru_state_array #(
    parameter  int S_INDEX  = 4,
    parameter  int NUM_WAYS = 4,
    localparam int WAY_IDX  = $clog2(NUM_WAYS),
    localparam int WIDTH    = NUM_WAYS - 1
) (
    input  logic               clk0,
    input  logic               rst0,
    output logic               ready,
    input  logic               csb0,
    input  logic [S_INDEX-1:0] addr0,
    output logic [WIDTH-1:0]   state0,
    output logic [WAY_IDX-1:0] victim0,
    input  logic               csb1,
    input  logic               web1,
    input  logic [S_INDEX-1:0] addr1,
    input  logic [WAY_IDX-1:0] way1
);

    localparam int NUM_SETS = 2 ** S_INDEX;

    // Heap-ordered tree, padded to NUM_WAYS bits so a WAY_IDX-bit
    // node number indexes it exactly. Each visited node points away
    // from the touched way.
    function automatic logic [WIDTH-1:0] plru_touch(
        input logic [WIDTH-1:0]   st,
        input logic [WAY_IDX-1:0] way
    );
        logic [NUM_WAYS-1:0] tree;
        logic [WAY_IDX-1:0]  node;
        logic [WAY_IDX-1:0]  w;
        logic                b;
        tree = {1'b0, st};
        node = '0;
        w    = way;
        for (int l = 0; l < WAY_IDX; l++) begin
            b          = w[WAY_IDX-1];
            tree[node] = ~b;
            node       = (node << 1) + WAY_IDX'(1) + WAY_IDX'(b);
            w          = w << 1;
        end
        return tree[WIDTH-1:0];
    endfunction

    function automatic logic [WAY_IDX-1:0] plru_victim(
        input logic [WIDTH-1:0] st
    );
        logic [NUM_WAYS-1:0] tree;
        logic [WAY_IDX-1:0]  node;
        logic [WAY_IDX-1:0]  v;
        logic                b;
        tree = {1'b0, st};
        node = '0;
        v    = '0;
        for (int l = 0; l < WAY_IDX; l++) begin
            b    = tree[node];
            v    = (v << 1) | WAY_IDX'(b);
            node = (node << 1) + WAY_IDX'(1) + WAY_IDX'(b);
        end
        return v;
    endfunction

    logic [WIDTH-1:0]   mem_q [NUM_SETS];
    logic [S_INDEX-1:0] addr0_q;
    logic [S_INDEX-1:0] addr1_q;
    logic [WAY_IDX-1:0] way1_q;
    logic               pend_q;

    logic               run;
    logic               acc0;
    logic               acc1;
    logic [WIDTH-1:0]   upd;
    logic [WIDTH-1:0]   st_out;
    logic               we;
    logic [S_INDEX-1:0] wa;
    logic [WIDTH-1:0]   wd;

    assign ready = run;
    assign acc0  = run & ~csb0;
    assign acc1  = run & ~csb1 & ~web1;

    // Back-to-back touches need no bypass: the write lands at the same
    // edge that captures the next touch, so its read sees the commit.
    assign upd = plru_touch(mem_q[addr1_q], way1_q);

    always_ff @(posedge clk0) begin
        if (rst0) begin
            addr0_q <= '0;
            addr1_q <= '0;
            way1_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            if (acc0) addr0_q <= addr0;
            if (acc1) begin
                addr1_q <= addr1;
                way1_q  <= way1;
            end
            pend_q <= acc1;
        end
    end

    // A lookup of the set being updated returns the in-flight value.
    always_comb begin
        st_out = mem_q[addr0_q];
        if (pend_q && (addr0_q == addr1_q)) st_out = upd;
        if (!run) st_out = '0;
    end

    assign state0  = st_out;
    assign victim0 = plru_victim(st_out);

`ifdef LRU_INIT_SWEEP_EN
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]         fsm_q;
    logic [0:0]         fsm_d;
    logic [S_INDEX-1:0] cnt_q;
    logic [S_INDEX-1:0] cnt_d;

    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        if (fsm_q == ST_INIT) begin
            cnt_d = cnt_q + S_INDEX'(1);
            if (cnt_q == S_INDEX'(NUM_SETS - 1)) fsm_d = ST_RUN;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            fsm_q <= ST_INIT;
            cnt_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
        end
    end

    assign run = (fsm_q == ST_RUN);
    // Reset suppresses the write so a pending touch is dropped.
    assign we  = ~rst0 & (~run | pend_q);
    assign wa  = run ? addr1_q : cnt_q;
    assign wd  = run ? upd : '0;

    // No reset on the storage so it can map onto a single-port RAM.
    always_ff @(posedge clk0) begin
        if (we) mem_q[wa] <= wd;
    end
`else
    assign run = 1'b1;
    assign we  = pend_q;
    assign wa  = addr1_q;
    assign wd  = upd;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            for (int s = 0; s < NUM_SETS; s++) mem_q[s] <= '0;
        end else if (we) begin
            mem_q[wa] <= wd;
        end
    end
`endif

endmodule

// File: tb/tb_plru_state_array.sv
// Self-checking bench for plru_state_array: directed vector table,
// reset corner cases and randomized traffic against a tree-PLRU model.
module tb_plru_state_array;

    localparam int SI = 4;
    localparam int NW = 4;
    localparam int WI = 2;
    localparam int W  = 3;
    localparam int NS = 16;
`ifdef LRU_INIT_SWEEP_EN
    localparam int INIT_CYC = 16;
`else
    localparam int INIT_CYC = 0;
`endif

    logic          clk0 = 1'b0;
    logic          rst0;
    logic          ready;
    logic          csb0;
    logic [SI-1:0] addr0;
    logic [W-1:0]  state0;
    logic [WI-1:0] victim0;
    logic          csb1;
    logic          web1;
    logic [SI-1:0] addr1;
    logic [WI-1:0] way1;

    int tests = 0;
    int fails = 0;

    // Model: per set, one bit per tree node (padded to NW bits).
    logic [NW-1:0] mdl [NS];
    logic [SI-1:0] mla;

    typedef struct {
        logic          c0;
        logic [SI-1:0] a0;
        logic          c1;
        logic          w1;
        logic [SI-1:0] a1;
        logic [WI-1:0] wy;
        logic [W-1:0]  es;
        logic [WI-1:0] ev;
    } vec_t;

    always #5 clk0 = ~clk0;

    plru_state_array #(
        .S_INDEX (SI),
        .NUM_WAYS(NW)
    ) dut (
        .clk0   (clk0),
        .rst0   (rst0),
        .ready  (ready),
        .csb0   (csb0),
        .addr0  (addr0),
        .state0 (state0),
        .victim0(victim0),
        .csb1   (csb1),
        .web1   (web1),
        .addr1  (addr1),
        .way1   (way1)
    );

    // Level l of way w's path is node (2^l - 1) + (w >> (WI-l));
    // it must point to the half that does not contain w.
    function automatic logic [NW-1:0] m_touch(
        input logic [NW-1:0] st,
        input logic [WI-1:0] w
    );
        logic [NW-1:0] r;
        logic [WI-1:0] n;
        int            wi;
        r  = st;
        wi = int'(w);
        for (int l = 0; l < WI; l++) begin
            n    = WI'(((1 << l) - 1) + (wi >> (WI - l)));
            r[n] = (((wi >> (WI - 1 - l)) & 1) == 0);
        end
        return r;
    endfunction

    // Follow the node bits down to a leaf, then map leaf to way.
    function automatic logic [WI-1:0] m_victim(input logic [NW-1:0] st);
        int            n;
        logic [WI-1:0] ni;
        n = 0;
        for (int l = 0; l < WI; l++) begin
            ni = WI'(n);
            n  = 2 * n + 1 + (st[ni] ? 1 : 0);
        end
        return WI'(n - (NW - 1));
    endfunction

    task automatic check(
        input string         name,
        input logic [W-1:0]  es,
        input logic [WI-1:0] ev
    );
        tests++;
        if (state0 !== es || victim0 !== ev) begin
            fails++;
            $display("FAIL %s: state0=%b victim0=%0d, expected %b/%0d",
                     name, state0, victim0, es, ev);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(
        input logic          c0,
        input logic [SI-1:0] a0,
        input logic          c1,
        input logic          w1,
        input logic [SI-1:0] a1,
        input logic [WI-1:0] wy
    );
        logic rdy;
        csb0  = c0;
        addr0 = a0;
        csb1  = c1;
        web1  = w1;
        addr1 = a1;
        way1  = wy;
        rdy   = ready;
        @(posedge clk0);
        if (rdy && !c0) mla = a0;
        if (rdy && !c1 && !w1) mdl[a1] = m_touch(mdl[a1], wy);
        #1;
    endtask

    task automatic idle();
        cyc(1'b1, '0, 1'b1, 1'b1, '0, '0);
    endtask

    task automatic do_reset();
        csb0  = 1'b1;
        csb1  = 1'b1;
        web1  = 1'b1;
        addr0 = '0;
        addr1 = '0;
        way1  = '0;
        rst0  = 1'b1;
        @(posedge clk0);
        #1;
        rst0 = 1'b0;
        foreach (mdl[i]) mdl[i] = '0;
        mla = '0;
        check("post_reset_out", 3'b000, 2'd0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 64) begin
            n++;
            @(posedge clk0);
            #1;
        end
    endtask

    vec_t tbl[$];
    int   n;

    initial begin
        tbl.push_back('{1'b0, 4'd5, 1'b1, 1'b1, 4'd0, 2'd0, 3'b000, 2'd0});
        tbl.push_back('{1'b1, 4'd0, 1'b0, 1'b0, 4'd5, 2'd0, 3'b011, 2'd2});
        tbl.push_back('{1'b1, 4'd9, 1'b1, 1'b1, 4'd0, 2'd0, 3'b011, 2'd2});
        tbl.push_back('{1'b0, 4'd5, 1'b1, 1'b1, 4'd0, 2'd0, 3'b011, 2'd2});
        tbl.push_back('{1'b0, 4'd5, 1'b0, 1'b0, 4'd5, 2'd2, 3'b110, 2'd1});
        tbl.push_back('{1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 2'd0, 3'b110, 2'd1});
        tbl.push_back('{1'b0, 4'd3, 1'b0, 1'b0, 4'd3, 2'd3, 3'b000, 2'd0});
        tbl.push_back('{1'b0, 4'd3, 1'b0, 1'b0, 4'd3, 2'd1, 3'b001, 2'd2});
        tbl.push_back('{1'b0, 4'd3, 1'b0, 1'b1, 4'd3, 2'd0, 3'b001, 2'd2});
        tbl.push_back('{1'b0, 4'd7, 1'b0, 1'b0, 4'd7, 2'd0, 3'b011, 2'd2});
        tbl.push_back('{1'b0, 4'd7, 1'b0, 1'b0, 4'd7, 2'd1, 3'b001, 2'd2});
        tbl.push_back('{1'b0, 4'd7, 1'b0, 1'b0, 4'd7, 2'd2, 3'b100, 2'd0});
        tbl.push_back('{1'b0, 4'd7, 1'b0, 1'b0, 4'd7, 2'd3, 3'b000, 2'd0});
        tbl.push_back('{1'b0, 4'd3, 1'b0, 1'b0, 4'd7, 2'd0, 3'b001, 2'd2});
        tbl.push_back('{1'b0, 4'd7, 1'b1, 1'b1, 4'd0, 2'd0, 3'b011, 2'd2});
        tbl.push_back('{1'b0, 4'd5, 1'b1, 1'b1, 4'd0, 2'd0, 3'b110, 2'd1});

        do_reset();
        wait_ready(n);
        check_int("init_ready_cycles", n, INIT_CYC);

        foreach (tbl[i]) begin
            cyc(tbl[i].c0, tbl[i].a0, tbl[i].c1, tbl[i].w1,
                tbl[i].a1, tbl[i].wy);
            check($sformatf("vec%0d", i), tbl[i].es, tbl[i].ev);
        end

        // Pending touch to set 9 killed by a reset on the next edge.
        cyc(1'b1, 4'd0, 1'b0, 1'b0, 4'd9, 2'd0);
        do_reset();
        wait_ready(n);
        check_int("reset_ready_cycles", n, INIT_CYC);
        cyc(1'b0, 4'd9, 1'b1, 1'b1, 4'd0, 2'd0);
        check("touch_dropped_by_reset", 3'b000, 2'd0);
        cyc(1'b0, 4'd5, 1'b1, 1'b1, 4'd0, 2'd0);
        check("reset_clears_set5", 3'b000, 2'd0);

`ifdef LRU_INIT_SWEEP_EN
        // Restart the sweep midway; a touch offered during INIT is ignored.
        do_reset();
        for (int k = 0; k < 8; k++) idle();
        cyc(1'b0, 4'd2, 1'b0, 1'b0, 4'd2, 2'd0);
        check("init_out_zero", 3'b000, 2'd0);
        do_reset();
        wait_ready(n);
        check_int("sweep_restart_cycles", n, 16);
        cyc(1'b0, 4'd2, 1'b1, 1'b1, 4'd0, 2'd0);
        check("init_touch_ignored", 3'b000, 2'd0);
`endif

        // Randomized traffic; narrow address range most of the time to
        // exercise forwarding and back-to-back touches of one set.
        for (int k = 0; k < 10000; k++) begin
            logic          c0, c1, w1;
            logic [SI-1:0] a0, a1;
            logic [WI-1:0] wy;
            c0 = ($urandom_range(0, 2) == 0);
            c1 = ($urandom_range(0, 3) == 0);
            w1 = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) begin
                a0 = SI'($urandom_range(0, NS - 1));
                a1 = SI'($urandom_range(0, NS - 1));
            end else begin
                a0 = SI'($urandom_range(0, 2));
                a1 = SI'($urandom_range(0, 2));
            end
            wy = WI'($urandom_range(0, NW - 1));
            cyc(c0, a0, c1, w1, a1, wy);
            check($sformatf("rand%0d", k), mdl[mla][W-1:0],
                  m_victim(mdl[mla]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
